// File: rtl/mularb_pkg.sv
// rtl/mularb_pkg.sv - shared MDU multiply encodings and round-robin grant helper
package mularb_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;

    // A lone eligible requester always wins; a tie goes to the pointer.
    function automatic logic [1:0] rr_grant(input logic [1:0] elig, input logic prio);
        if (&elig) return prio ? 2'b10 : 2'b01;
        return elig;
    endfunction

endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled flop with synchronous active-high reset
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mularb_rrarb2.sv
// rtl/mularb_rrarb2.sv - two-way round-robin arbiter with priority pointer
module rrarb2
    import mularb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] elig,
    output logic [1:0] grant,
    output logic       prio
);

    assign grant = rr_grant(elig, prio);

    // After a grant the pointer favours the loser.
    always_ff @(posedge clk) begin
        if (reset)                 prio <= 1'b0;
        else if (en && (|grant))   prio <= ~grant[1];
    end

endmodule

// File: rtl/mularb.sv
// rtl/mularb.sv - two-requester arbiter/sequencer for the shared pipelined multiplier
module mularb
    import mularb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ReqValid,
    output logic [1:0]        ReqReady,
    input  logic [XLEN-1:0]   ReqSrcA0,
    input  logic [XLEN-1:0]   ReqSrcB0,
    input  logic [XLEN-1:0]   ReqSrcA1,
    input  logic [XLEN-1:0]   ReqSrcB1,
    input  logic [2:0]        ReqFunct3_0,
    input  logic [2:0]        ReqFunct3_1,
    input  logic [1:0]        Flush,
    output logic [XLEN-1:0]   MulSrcA,
    output logic [XLEN-1:0]   MulSrcB,
    output logic [2:0]        MulFunct3,
    output logic              MulStall,
    input  logic [2*XLEN-1:0] MulProd,
    output logic [1:0]        RspValid,
    input  logic [1:0]        RspReady,
    output logic [2*XLEN-1:0] RspProd,
    output logic [XLEN-1:0]   IssueCnt0,
    output logic [XLEN-1:0]   IssueCnt1
);

    logic       SlotValid, SlotTag;
    logic       Kill, Adv, Issue, Winner, Sel, Prio;
    logic [1:0] Elig, Grant;

    assign Kill     = SlotValid & Flush[SlotTag];
    assign Adv      = ~SlotValid | Kill | RspReady[SlotTag];
    assign MulStall = ~Adv;
    assign Elig     = ReqValid & ~Flush;

    rrarb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (Adv),
        .elig  (Elig),
        .grant (Grant),
        .prio  (Prio)
    );

    assign ReqReady = (Adv && !reset) ? Grant : 2'b00;
    assign Issue    = |ReqReady;
    assign Winner   = Grant[1];

    // With no winner the operands still come from somewhere; the slot stays invalid.
    assign Sel       = (|Grant) ? Winner : Prio;
    assign MulSrcA   = Sel ? ReqSrcA1    : ReqSrcA0;
    assign MulSrcB   = Sel ? ReqSrcB1    : ReqSrcB0;
    assign MulFunct3 = Sel ? ReqFunct3_1 : ReqFunct3_0;

    // The slot tracks the multiplier register stage, so it shares its enable.
    flopenr #(.WIDTH(2)) u_slot (
        .clk   (clk),
        .reset (reset),
        .en    (Adv),
        .d     ({Issue, Winner}),
        .q     ({SlotValid, SlotTag})
    );

    assign RspValid[0] = SlotValid & ~SlotTag & ~Flush[0];
    assign RspValid[1] = SlotValid &  SlotTag & ~Flush[1];
    assign RspProd     = MulProd;

    always_ff @(posedge clk) begin
        if (reset) begin
            IssueCnt0 <= '0;
            IssueCnt1 <= '0;
        end else begin
            if (ReqReady[0]) IssueCnt0 <= IssueCnt0 + XLEN'(1);
            if (ReqReady[1]) IssueCnt1 <= IssueCnt1 + XLEN'(1);
        end
    end

endmodule

// File: tb/tb_mularb.sv
// tb/tb_mularb.sv - randomized self-checking bench for mularb against a queue-based model
module tb_mularb;
    import mularb_pkg::*;

    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        ReqValid, ReqReady, Flush, RspValid, RspReady;
    logic [XLEN-1:0]   ReqSrcA0, ReqSrcB0, ReqSrcA1, ReqSrcB1;
    logic [2:0]        ReqFunct3_0, ReqFunct3_1, MulFunct3;
    logic [XLEN-1:0]   MulSrcA, MulSrcB, IssueCnt0, IssueCnt1;
    logic              MulStall;
    logic [2*XLEN-1:0] MulProd, RspProd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mularb #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqSrcA0(ReqSrcA0), .ReqSrcB0(ReqSrcB0),
        .ReqSrcA1(ReqSrcA1), .ReqSrcB1(ReqSrcB1),
        .ReqFunct3_0(ReqFunct3_0), .ReqFunct3_1(ReqFunct3_1),
        .Flush(Flush),
        .MulSrcA(MulSrcA), .MulSrcB(MulSrcB), .MulFunct3(MulFunct3),
        .MulStall(MulStall), .MulProd(MulProd),
        .RspValid(RspValid), .RspReady(RspReady), .RspProd(RspProd),
        .IssueCnt0(IssueCnt0), .IssueCnt1(IssueCnt1)
    );

    function automatic logic [2*XLEN-1:0] fullprod(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic [2:0] f3);
        logic [2*XLEN-1:0] ea, eb;
        ea = (f3 == MULHU) ? {{XLEN{1'b0}}, a} : {{XLEN{a[XLEN-1]}}, a};
        eb = (f3 == MULHU || f3 == MULHSU) ? {{XLEN{1'b0}}, b} : {{XLEN{b[XLEN-1]}}, b};
        return ea * eb;
    endfunction

    // Stand-in for the pipelined multiplier: one register stage, enable = ~MulStall.
    always @(posedge clk) if (!MulStall) MulProd <= fullprod(MulSrcA, MulSrcB, MulFunct3);

    task automatic chk(input string name, input logic [2*XLEN-1:0] act, input logic [2*XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              tag;
        logic [2*XLEN-1:0] prod;
    } op_t;

    op_t             inflight[$];
    logic            m_prio;
    logic [XLEN-1:0] m_cnt0, m_cnt1;

    always @(negedge clk) begin
        logic v, tag, adv;
        logic [1:0] elig, exp_rr, exp_rv;
        int win;
        op_t o;
        if (reset) begin
            chk("reset_reqready", {126'd0, ReqReady}, '0);
            inflight.delete();
            m_prio = 1'b0;
            m_cnt0 = '0;
            m_cnt1 = '0;
        end else begin
            v   = inflight.size() != 0;
            tag = v ? inflight[0].tag : 1'b0;
            adv = !v || Flush[tag] || RspReady[tag];
            elig = ReqValid & ~Flush;
            if (elig == 2'b11) win = int'(m_prio);
            else if (elig[0])  win = 0;
            else if (elig[1])  win = 1;
            else               win = -1;
            exp_rr = (adv && win >= 0) ? (2'b01 << win) : 2'b00;
            exp_rv = (v && !Flush[tag]) ? (2'b01 << tag) : 2'b00;
            chk("reqready", {126'd0, ReqReady}, {126'd0, exp_rr});
            chk("rspvalid", {126'd0, RspValid}, {126'd0, exp_rv});
            chk("mulstall", {127'd0, MulStall}, {127'd0, !adv});
            chk("issuecnt0", {64'd0, IssueCnt0}, {64'd0, m_cnt0});
            chk("issuecnt1", {64'd0, IssueCnt1}, {64'd0, m_cnt1});
            if (exp_rv != 2'b00) chk("rspprod", RspProd, inflight[0].prod);
            if (adv) begin
                if (v) void'(inflight.pop_front());
                if (win >= 0) begin
                    o.tag  = (win == 1);
                    o.prod = (win == 1) ? fullprod(ReqSrcA1, ReqSrcB1, ReqFunct3_1)
                                        : fullprod(ReqSrcA0, ReqSrcB0, ReqFunct3_0);
                    inflight.push_back(o);
                    m_prio = (win == 0);
                    if (win == 1) m_cnt1 = m_cnt1 + 1;
                    else          m_cnt0 = m_cnt0 + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ReqValid = '0; Flush = '0; RspReady = '0;
        ReqSrcA0 = '0; ReqSrcB0 = '0; ReqSrcA1 = '0; ReqSrcB1 = '0;
        ReqFunct3_0 = MUL; ReqFunct3_1 = MUL;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single request from port 0
        ReqValid = 2'b01; ReqSrcA0 = 3; ReqSrcB0 = 5; RspReady = 2'b11;
        #1 chk("t1_reqready", {126'd0, ReqReady}, 2'b01);
        tick(); ReqValid = 2'b00;
        #1 chk("t1_rspvalid", {126'd0, RspValid}, 2'b01);
        chk("t1_prod", RspProd, 15);
        chk("t1_cnt0", {64'd0, IssueCnt0}, 1);

        // Both requesting continuously after reset
        reset = 1'b1; tick(); reset = 1'b0;
        ReqValid = 2'b11; ReqSrcA1 = 7; ReqSrcB1 = 6; RspReady = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_grant", {126'd0, ReqReady}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("t2_rspvalid", {126'd0, RspValid}, (k % 2 == 1) ? 2'b01 : 2'b10);
            tick();
        end

        // Port 1 result held back for three cycles
        ReqValid = 2'b01; RspReady = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t3_stall", {127'd0, MulStall}, 1);
            chk("t3_reqready", {126'd0, ReqReady}, 2'b00);
            chk("t3_rspvalid", {126'd0, RspValid}, 2'b10);
            chk("t3_prod", RspProd, 42);
            tick();
        end
        RspReady = 2'b11;
        #1 chk("t3_release", {126'd0, ReqReady}, 2'b01);
        tick();

        // Flush of port 1 frees the slot for port 0
        ReqValid = 2'b10; tick();
        ReqValid = 2'b01; Flush = 2'b10; RspReady = 2'b00;
        #1 chk("t4_rspvalid", {126'd0, RspValid}, 2'b00);
        chk("t4_reqready", {126'd0, ReqReady}, 2'b01);
        tick(); Flush = 2'b00; ReqValid = 2'b00; RspReady = 2'b11;
        #1 chk("t4_cnt0", {64'd0, IssueCnt0}, 4);
        chk("t4_cnt1", {64'd0, IssueCnt1}, 3);
        chk("t4_rspvalid_after", {126'd0, RspValid}, 2'b01);
        chk("t4_prod", RspProd, 15);

        // Signed product on port 1
        ReqValid = 2'b10; ReqSrcA1 = 64'hFFFF_FFFF_FFFF_FFFE; ReqSrcB1 = 3; ReqFunct3_1 = MULH;
        #1 chk("t5_reqready", {126'd0, ReqReady}, 2'b10);
        tick(); ReqValid = 2'b00;
        #1 chk("t5_rspvalid", {126'd0, RspValid}, 2'b10);
        chk("t5_prod", RspProd, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);

        // Reset with the slot occupied
        RspReady = 2'b10; ReqValid = 2'b01;
        #1 chk("t6_issue", {126'd0, ReqReady}, 2'b01);
        tick(); RspReady = 2'b00; ReqValid = 2'b00;
        #1 chk("t6_inflight", {126'd0, RspValid}, 2'b01);
        reset = 1'b1; tick(); reset = 1'b0;
        ReqValid = 2'b11; RspReady = 2'b11;
        #1 chk("t6_rspvalid", {126'd0, RspValid}, 2'b00);
        chk("t6_cnt0", {64'd0, IssueCnt0}, 0);
        chk("t6_cnt1", {64'd0, IssueCnt1}, 0);
        chk("t6_prio", {126'd0, ReqReady}, 2'b01);
        tick();

        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            ReqValid    = 2'($urandom);
            RspReady    = 2'($urandom);
            Flush       = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            ReqSrcA0    = {$urandom, $urandom};
            ReqSrcB0    = {$urandom, $urandom};
            ReqSrcA1    = {$urandom, $urandom};
            ReqSrcB1    = {$urandom, $urandom};
            ReqFunct3_0 = 3'($urandom_range(0, 3));
            ReqFunct3_1 = 3'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mularb.md
# mularb

Two-requester arbiter and sequencer for the shared pipelined integer multiplier (`mul`). Two requesters issue multiplies through valid/ready handshakes:
- port 0: the integer MDU;
- port 1: a secondary unit, e.g. bit-manipulation/crypto.

The block grants the multiplier round-robin, tags each in-flight operation, and steers the product back to its owner. It stalls the multiplier register stage while a result is unaccepted and supports per-requester flush. It sits between the requesters and the `mul` instance in the execute/memory boundary.

## Interface
- `XLEN`, default 64: operand width; the product is 2*XLEN.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `ReqValid`  in  2  per-requester request valid
- `ReqReady`  out  2  per-requester accept
- `ReqSrcA0`, `ReqSrcB0`, `ReqSrcA1`, `ReqSrcB1`  in  XLEN  operands
- `ReqFunct3_0`, `ReqFunct3_1`  in  3  multiply type, same encoding as the multiplier
- `Flush`  in  2  per-requester kill
- `MulSrcA`, `MulSrcB`  out  XLEN  operands to the multiplier
- `MulFunct3`  out  3  type to the multiplier
- `MulStall`  out  1  drives the multiplier register-stage stall (enable = ~MulStall); multiplier flush is tied low
- `MulProd`  in  2*XLEN  product from the multiplier, valid one cycle after issue
- `RspValid`  out  2  per-requester result valid
- `RspReady`  in  2  per-requester result accept
- `RspProd`  out  2*XLEN  result, shared by both ports
- `IssueCnt0`, `IssueCnt1`  out  XLEN  per-requester accepted-request counters

## Operation
- **Slot state:** `SlotValid`, `SlotTag` (1 bit, owner) mirror the multiplier register stage.
- **Kill:** `Kill = SlotValid & Flush[SlotTag]`.
- **Advance:** `Adv = ~SlotValid | Kill | RspReady[SlotTag]`.
- **Stall output:** `MulStall = ~Adv`.
- **Arbitration:**
  - Eligibility: `Elig[i] = ReqValid[i] & ~Flush[i]`.
  - Single eligible requester: it wins.
  - Both eligible: the requester indicated by priority pointer `Prio` wins.
- **Grant and issue:**
  - `ReqReady[i] = Adv & Grant[i]`.
  - Issue occurs when any `ReqReady` bit is high.
- **Issue effects (next edge):**
  - `SlotValid <= 1`, `SlotTag <= winner`.
  - `Prio <= ~winner`.
  - `IssueCnt[winner]` increments, wrapping at 2^XLEN.
- **Adv with no issue (next edge):** `SlotValid <= 0`.
- **Stall (~Adv):** slot state, `Prio` and counters hold.
- **Operand steering:** `MulSrcA/B` and `MulFunct3` come from the winner. With no winner, they come from requester `Prio`; the values are don't-care because the slot is not marked valid.
- **Response:**
  - `RspValid[i] = SlotValid & (SlotTag == i) & ~Flush[i]`.
  - `RspProd = MulProd` combinationally.
  - Completion = `RspValid[i] & RspReady[i]`.
- **Flush:**
  - Flush in the same cycle as `RspReady` wins: no completion, and the slot is freed.
  - A flushed requester cannot be granted that cycle.
  - The other requester may issue into the freed slot in the same cycle.
- **Back-to-back:** with `RspReady` held high, one issue per cycle is sustained (throughput 1/cycle).

## Timing
- **Reset values:**
  - Internal: `SlotValid=0`, `SlotTag=0`, `Prio=0` (requester 0 favoured first).
  - Outputs: `RspValid=0`, `ReqReady=0` for the reset cycle, `MulStall=0`, `IssueCnt0/1=0`.
- **Reset mid-operation:** discards the in-flight slot; no response is produced.
- **Latency:** accept at edge t, then `RspValid` is high in cycle t+1. Data is valid while `RspValid` is high and held stable during stall.
- **Combinational paths:** `ReqReady` depends combinationally on `RspReady`/`Flush` (via `Adv`). Requesters must not derive `RspReady` from `ReqReady`.
- **Request rule:** `ReqValid` may drop without being accepted; there is no stickiness requirement.

## Structure
- **Sub-module `rrarb2`:** 2-way round-robin arbiter with inputs `Elig`, `Prio`, `clk`/`reset`/`en`, and outputs `Grant`, pointer update.
- **Datapath:** the slot register uses the existing `flopenr` cell.
- **Shared MDU package:** holds the multiply Funct3 encodings (`MUL`, `MULH`, `MULHSU`, `MULHU`); add them there if absent.
- **No local typedefs are needed.**

## Test plan
1. **Single request:** port 0, A=3, B=5, Funct3=000, `RspReady` high. Expect `ReqReady0` high at t, `RspValid=2'b01` at t+1 with `RspProd=15`, and `IssueCnt0=1`.
2. **Simultaneous requests:** both requesting continuously after reset, `RspReady=2'b11`. Grants alternate 0,1,0,1, and `RspValid` alternates 01,10,01,10 one cycle later.
3. **Stall:** response owned by port 1 with `RspReady1` low for 3 cycles, port 0 requesting. Expect `MulStall=1` and `ReqReady=0` for 3 cycles with `RspProd` stable; port 0 is granted in the cycle `RspReady1` rises.
4. **Flush kill:** `Flush1` asserted while slot tag=1 and port 0 requesting. Expect `RspValid1=0`, port 0 granted the same cycle, and no completion counted for port 1.
5. **Signed product:** port 1, Funct3=001, A=-2, B=3, XLEN=64. Expect `RspProd=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA`.
6. **Reset mid-flight:** reset with the slot valid. Expect `RspValid=0` next cycle, counters=0, and `Prio=0`.
